// File: rtl/median_avg_pkg.sv
// Shared types and sizing for the median/average sample path.
// Widths, group size and the rd-to-ack latency live here.
package median_avg_pkg;
    localparam int DATA_W  = 16;
    localparam int AVG_W   = 8;
    localparam int N_LOG2  = 3;
    localparam int ACK_DLY = 4;
    localparam int ACC_W   = DATA_W + N_LOG2;

    typedef logic [DATA_W-1:0] sample_t;
endpackage

// File: rtl/median_avg_median3.sv
// Combinational median of three unsigned samples.
// Uses max(min(a,b), min(max(a,b),c)).
module median3
    import median_avg_pkg::*;
(
    input  sample_t a,
    input  sample_t b,
    input  sample_t c,
    output sample_t med
);
    sample_t lo;
    sample_t hi;
    sample_t hm;

    always_comb begin
        lo  = (a < b) ? a : b;
        hi  = (a < b) ? b : a;
        hm  = (hi < c) ? hi : c;
        med = (lo > hm) ? lo : hm;
    end
endmodule

// File: rtl/median_avg_top.sv
// Sample path: strobe sync, 3-tap median, delayed-ack accumulator
// producing the floor mean of every 8 medians, saturated to 8 bits.
module median_avg_top
    import median_avg_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  sample_t          data_i,
    input  logic             data_av_ai,
    output sample_t          median_o,
    output logic [AVG_W-1:0] avg_o
);
    logic              sync1;
    logic              sync2;
    logic              sync3;
    logic              sample_stb;
    logic              control_rd;
    logic              interrupt_ack;
    sample_t           w0;
    sample_t           w1;
    sample_t           w2;
    sample_t           med;
    logic [ACK_DLY-1:0] dl_v;
    sample_t           dl_d [ACK_DLY];
    sample_t           ack_med;
    logic [ACC_W-1:0]  acc;
    logic [ACC_W-1:0]  acc_next;
    logic [ACC_W-1:0]  avg_full;
    logic [AVG_W-1:0]  avg_sat;
    logic [N_LOG2-1:0] cnt;

    assign sample_stb    = sync2 & ~sync3;
    assign interrupt_ack = dl_v[ACK_DLY-1];
    assign ack_med       = dl_d[ACK_DLY-1];

    median3 u_med (
        .a   (w0),
        .b   (w1),
        .c   (w2),
        .med (med)
    );

    always_comb begin
        acc_next = acc + ACC_W'(ack_med);
        avg_full = acc_next >> N_LOG2;
        avg_sat  = avg_full[AVG_W-1:0];
        if (|avg_full[ACC_W-1:AVG_W])
            avg_sat = '1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1      <= 1'b0;
            sync2      <= 1'b0;
            sync3      <= 1'b0;
            control_rd <= 1'b0;
            w0         <= '0;
            w1         <= '0;
            w2         <= '0;
            median_o   <= '0;
        end else begin
            sync1      <= data_av_ai;
            sync2      <= sync1;
            sync3      <= sync2;
            control_rd <= sample_stb;
            if (sample_stb) begin
                w2 <= w1;
                w1 <= w0;
                w0 <= data_i;
            end
            if (control_rd)
                median_o <= med;
        end
    end

    // Median snapshots ride with their rd pulse so overlapping samples queue in order
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            dl_v <= '0;
            for (int i = 0; i < ACK_DLY; i++)
                dl_d[i] <= '0;
        end else begin
            dl_v <= {dl_v[ACK_DLY-2:0], control_rd};
            dl_d[0] <= med;
            for (int i = 1; i < ACK_DLY; i++)
                dl_d[i] <= dl_d[i-1];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            acc   <= '0;
            cnt   <= '0;
            avg_o <= '0;
        end else if (interrupt_ack) begin
            cnt <= cnt + N_LOG2'(1);
            if (cnt == '1) begin
                avg_o <= avg_sat;
                acc   <= '0;
            end else begin
                acc <= acc_next;
            end
        end
    end
endmodule

// File: tb/tb_median_avg_top.sv
// Directed bench for median_avg_top: medians, group averages,
// saturation, reset mid-group, strobe hold and close strobes.
module tb_median_avg_top;
    import median_avg_pkg::*;

    logic             clk_i = 1'b0;
    logic             rst_i;
    sample_t          data_i;
    logic             data_av_ai;
    sample_t          median_o;
    logic [AVG_W-1:0] avg_o;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int rd_cnt = 0;
    int ack_cnt = 0;
    int rst_rd = 0;
    int rd_cyc = 0;
    int ack_cyc = 0;

    sample_t seq [8] = '{16'd150, 16'd100, 16'd10, 16'd40,
                         16'd250, 16'd110, 16'd35, 16'd200};
    int      med_exp [8] = '{0, 100, 100, 40, 40, 110, 110, 110};

    median_avg_top dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .data_i     (data_i),
        .data_av_ai (data_av_ai),
        .median_o   (median_o),
        .avg_o      (avg_o)
    );

    always #5 clk_i = ~clk_i;

    always @(negedge clk_i) begin
        cyc <= cyc + 1;
        if (rst_i) begin
            rd_cnt  <= 0;
            ack_cnt <= 0;
            if (dut.control_rd)
                rst_rd <= rst_rd + 1;
        end else begin
            if (dut.control_rd) begin
                rd_cnt <= rd_cnt + 1;
                rd_cyc <= cyc;
            end
            if (dut.interrupt_ack) begin
                ack_cnt <= ack_cnt + 1;
                ack_cyc <= cyc;
            end
        end
    end

    ap_ack: assert property (@(posedge clk_i) disable iff (rst_i)
        dut.control_rd |-> ##4 dut.interrupt_ack)
        else $error("FAIL ack_assert: interrupt_ack not 4 cycles after control_rd");

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got=%0d want=%0d", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst_i      = 1'b1;
        data_i     = 16'd999;
        data_av_ai = 1'b1;
        repeat (3) @(negedge clk_i);
        data_av_ai = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b0;
        repeat (2) @(negedge clk_i);
    endtask

    task automatic send(input sample_t v, input int hi, input int lo);
        data_i     = v;
        data_av_ai = 1'b1;
        repeat (hi) @(negedge clk_i);
        data_av_ai = 1'b0;
        repeat (lo) @(negedge clk_i);
    endtask

    task automatic run_seq(input string tag);
        for (int i = 0; i < 8; i++) begin
            send(seq[i], 2, 2);
            chk($sformatf("%s_med%0d", tag, i), int'(median_o), med_exp[i]);
        end
        repeat (10) @(negedge clk_i);
    endtask

    initial begin
        rst_i      = 1'b1;
        data_i     = '0;
        data_av_ai = 1'b0;
        @(negedge clk_i);
        do_reset();
        chk("rst_median", int'(median_o), 0);
        chk("rst_avg", int'(avg_o), 0);
        chk("rst_no_rd", rst_rd, 0);

        send(16'd150, 2, 8);
        chk("single_median", int'(median_o), 0);
        chk("single_rd", rd_cnt, 1);
        chk("single_ack", ack_cnt, 1);
        chk("single_ack_dly", ack_cyc - rd_cyc, 4);

        do_reset();
        send(16'd150, 2, 2);
        data_i     = 16'd100;
        data_av_ai = 1'b1;
        repeat (4) @(negedge clk_i);
        chk("latency_median", int'(median_o), 100);
        data_av_ai = 1'b0;
        repeat (2) @(negedge clk_i);

        do_reset();
        run_seq("seq");
        chk("seq_avg", int'(avg_o), 76);
        chk("seq_rd", rd_cnt, 8);
        chk("seq_ack", ack_cnt, 8);

        do_reset();
        for (int i = 0; i < 8; i++)
            send(16'd1000, 2, 2);
        repeat (10) @(negedge clk_i);
        chk("sat_median", int'(median_o), 1000);
        chk("sat_avg", int'(avg_o), 255);

        do_reset();
        for (int i = 0; i < 5; i++)
            send(16'd500, 2, 2);
        do_reset();
        chk("midrst_median", int'(median_o), 0);
        chk("midrst_avg", int'(avg_o), 0);
        run_seq("midrst");
        chk("midrst_seq_avg", int'(avg_o), 76);

        do_reset();
        send(16'd500, 5, 3);
        repeat (6) @(negedge clk_i);
        chk("hold_rd", rd_cnt, 1);
        chk("hold_median", int'(median_o), 0);
        data_i = 16'd777;
        repeat (6) @(negedge clk_i);
        chk("idle_data_rd", rd_cnt, 1);
        chk("idle_data_median", int'(median_o), 0);

        do_reset();
        send(16'd120, 1, 1);
        send(16'd120, 1, 3);
        chk("close_rd", rd_cnt, 2);
        for (int i = 0; i < 6; i++)
            send(16'd120, 2, 2);
        repeat (10) @(negedge clk_i);
        chk("close_total_rd", rd_cnt, 8);
        chk("close_total_ack", ack_cnt, 8);
        chk("close_median", int'(median_o), 120);
        chk("close_avg", int'(avg_o), 105);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
